// File: rtl/usb_buffer_pkg.sv
// Shared types for the USB data-buffer access path: arbiter FSM states,
// grant owner encoding and the AHB transfer-size codes.
package usb_buffer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_XFER    = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESP    = 2'd3
    } state_t;

    typedef enum logic {
        GNT_AHB = 1'b0,
        GNT_USB = 1'b1
    } grant_t;

    localparam logic [1:0] SIZE_BYTE    = 2'd0;
    localparam logic [1:0] SIZE_HALF    = 2'd1;
    localparam logic [1:0] SIZE_WORD    = 2'd2;
    localparam logic [1:0] SIZE_ILLEGAL = 2'd3;

    // Byte count for an AHB size code; the illegal code maps to 0 and is rejected upstream.
    function automatic logic [2:0] size_to_len(input logic [1:0] size);
        logic [2:0] len;
        case (size)
            SIZE_BYTE: len = 3'd1;
            SIZE_HALF: len = 3'd2;
            SIZE_WORD: len = 3'd4;
            default:   len = 3'd0;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/occupancy_counter.sv
// Up/down byte counter for buffer fill level, saturating at 0 and DEPTH,
// with a synchronous clear used by flush.
module occupancy_counter #(
    parameter int DEPTH = 64,
    parameter int W     = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] MAX = W'(DEPTH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !dec && count != MAX) begin
            count <= count + 1'b1;
        end else if (dec && !inc && count != '0) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/buffer_access_arbiter.sv
// Round-robin arbiter between AHB (1/2/4-byte) and USB (1-byte) accesses to a
// byte-wide data buffer, with occupancy tracking and flush abort.
//
//   state      | meaning
//   -----------+-------------------------------------------------------
//   ST_IDLE    | waiting for a request; grant and accept/reject checks
//   ST_XFER    | one buf_we/buf_re per cycle for N bytes
//   ST_CAPTURE | last get byte arrives on buf_rdata
//   ST_RESP    | one-cycle done pulse to the granted requester
module buffer_access_arbiter
    import usb_buffer_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ahb_req,
    input  logic        ahb_write,
    input  logic [1:0]  ahb_size,
    input  logic [31:0] ahb_wdata,
    output logic [31:0] ahb_rdata,
    output logic        ahb_done,
    output logic        ahb_err,
    input  logic        usb_req,
    input  logic        usb_write,
    input  logic [7:0]  usb_wdata,
    output logic [7:0]  usb_rdata,
    output logic        usb_done,
    output logic        usb_err,
    input  logic        flush,
    output logic        buf_we,
    output logic        buf_re,
    output logic [7:0]  buf_wdata,
    input  logic [7:0]  buf_rdata,
    output logic [6:0]  buffer_occupancy
);

    state_t      state, state_nxt;
    grant_t      gnt, last_gnt, sel;
    logic        grant, reject, sel_write, dir_wr, rej_r, rd_pending, finish;
    logic [2:0]  req_len, len;
    logic [1:0]  idx, cap_idx;
    logic [31:0] sel_wdata, wdata, rbuf, rbuf_merged;
    logic [6:0]  occ;

    occupancy_counter #(.DEPTH(DEPTH), .W(7)) u_occ (
        .clk   (clk),
        .rst   (rst),
        .clr   (flush),
        .inc   (buf_we),
        .dec   (buf_re),
        .count (occ)
    );

    assign buffer_occupancy = occ;

    always_comb begin
        if (ahb_req && usb_req) begin
            sel = (last_gnt == GNT_USB) ? GNT_AHB : GNT_USB;
        end else if (usb_req) begin
            sel = GNT_USB;
        end else begin
            sel = GNT_AHB;
        end
        sel_write = (sel == GNT_AHB) ? ahb_write : usb_write;
        sel_wdata = (sel == GNT_AHB) ? ahb_wdata : {24'd0, usb_wdata};
        req_len   = (sel == GNT_AHB) ? size_to_len(ahb_size) : 3'd1;
        reject    = ((sel == GNT_AHB) && (ahb_size == SIZE_ILLEGAL))
                 || (sel_write && (({1'b0, occ} + {5'd0, req_len}) > 8'(DEPTH)))
                 || (!sel_write && (occ < {4'd0, req_len}));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        buf_we    = 1'b0;
        buf_re    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ahb_req || usb_req) begin
                    grant     = 1'b1;
                    state_nxt = reject ? ST_RESP : ST_XFER;
                end
            end
            ST_XFER: begin
                buf_we = dir_wr;
                buf_re = !dir_wr;
                if ({1'b0, idx} == len - 3'd1) begin
                    state_nxt = dir_wr ? ST_RESP : ST_CAPTURE;
                end
            end
            ST_CAPTURE: state_nxt = ST_RESP;
            ST_RESP:    state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
        if (flush) begin
            state_nxt = ST_IDLE;
            grant     = 1'b0;
            buf_we    = 1'b0;
            buf_re    = 1'b0;
        end
    end

    // A flush in any busy state ends the access with an error completion.
    assign finish    = (state == ST_RESP) || (flush && state != ST_IDLE);
    assign ahb_done  = finish && (gnt == GNT_AHB);
    assign usb_done  = finish && (gnt == GNT_USB);
    assign ahb_err   = ahb_done && (rej_r || flush);
    assign usb_err   = usb_done && (rej_r || flush);
    assign buf_wdata = buf_we ? wdata[{idx, 3'b000} +: 8] : 8'd0;

    always_comb begin
        rbuf_merged = rbuf;
        if (rd_pending) begin
            rbuf_merged[{cap_idx, 3'b000} +: 8] = buf_rdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt        <= GNT_AHB;
            last_gnt   <= GNT_USB;
            dir_wr     <= 1'b0;
            rej_r      <= 1'b0;
            len        <= 3'd0;
            wdata      <= '0;
            idx        <= 2'd0;
            cap_idx    <= 2'd0;
            rd_pending <= 1'b0;
            rbuf       <= '0;
            ahb_rdata  <= '0;
            usb_rdata  <= '0;
        end else begin
            rd_pending <= buf_re;
            cap_idx    <= idx;
            if (grant) begin
                gnt      <= sel;
                last_gnt <= sel;
                dir_wr   <= sel_write;
                rej_r    <= reject;
                len      <= req_len;
                wdata    <= sel_wdata;
                idx      <= 2'd0;
                rbuf     <= '0;
            end else begin
                rbuf <= rbuf_merged;
                if (buf_we || buf_re) begin
                    idx <= idx + 1'b1;
                end
            end
            if (state == ST_CAPTURE && !flush) begin
                if (gnt == GNT_AHB) begin
                    ahb_rdata <= rbuf_merged;
                end else begin
                    usb_rdata <= rbuf_merged[7:0];
                end
            end
        end
    end

endmodule
